// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game-state store.
package snake_pkg;

    localparam int FIELD_X_MAX = 20;
    localparam int FIELD_Y_MAX = 11;

    localparam logic [4:0] START_X   = 5'd10;
    localparam logic [3:0] START_Y   = 4'd6;
    localparam int         START_LEN = 3;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SCAN
    } state_t;

    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
    } pos_t;

    // Anything outside x 1..20, y 1..11 is wall.
    function automatic logic is_wall(input pos_t p);
        return (p.x == 5'd0) || (p.x > 5'(FIELD_X_MAX)) ||
               (p.y == 4'd0) || (p.y > 4'(FIELD_Y_MAX));
    endfunction

    // Right<->left and down<->up differ only in bit 1.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// Tick/direction/eat inputs and segment stream outputs of the snake store.
interface snake_body_if #(
    parameter int MAX_LEN = 32
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic          i_tick;
    logic [1:0]    i_dir;
    logic          i_eat;
    logic [4:0]    o_snake_x;
    logic [3:0]    o_snake_y;
    logic          o_snake_first;
    logic          o_snake_last;
    logic          o_snake_valid;
    logic [LW-1:0] o_length;
    logic          o_game_over;

    modport master (
        output i_tick, i_dir, i_eat,
        input  o_snake_x, o_snake_y, o_snake_first, o_snake_last,
               o_snake_valid, o_length, o_game_over
    );

    modport slave (
        input  i_tick, i_dir, i_eat,
        output o_snake_x, o_snake_y, o_snake_first, o_snake_last,
               o_snake_valid, o_length, o_game_over
    );
endinterface

// File: rtl/snake_ring.sv
// Circular segment buffer: head/tail pointers plus a read pointer that
// walks backward from the head towards the tail during a scan.
module snake_ring
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic we_i,          // append new head
    input  logic grow_i,        // keep tail on this append
    input  pos_t wdata_i,
    input  logic rd_start_i,    // point reader at the segment behind the head
    input  logic rd_next_i,     // step reader one segment towards the tail
    output pos_t rdata_o,
    output logic rd_is_tail_o
);
    localparam int PW = $clog2(MAX_LEN);

    pos_t          mem_q [MAX_LEN];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] rd_q;

    // Storage and pointers; reset lays the start body out tail-first at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN)
                    mem_q[i] <= '{x: 5'(int'(START_X) - START_LEN + 1 + i), y: START_Y};
                else
                    mem_q[i] <= '0;
            end
            head_q <= PW'(START_LEN - 1);
            tail_q <= '0;
            rd_q   <= '0;
        end else begin
            if (we_i) begin
                mem_q[head_q + 1'b1] <= wdata_i;
                head_q <= head_q + 1'b1;
                if (!grow_i)
                    tail_q <= tail_q + 1'b1;
            end
            // After an append the old head slot is the second segment.
            if (rd_start_i)
                rd_q <= we_i ? head_q : head_q - 1'b1;
            else if (rd_next_i)
                rd_q <= rd_q - 1'b1;
        end
    end

    assign rdata_o      = mem_q[rd_q];
    assign rd_is_tail_o = (rd_q == tail_q);

endmodule

// File: rtl/snake_body.sv
// Snake game-state store: moves the head one cell per tick, then streams
// the body head-first while checking self collision and collecting eats.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    snake_body_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    state_t        state_q;
    dir_t          dir_q;
    pos_t          head_q;
    logic [LW-1:0] len_q;
    logic          grow_q;
    logic          go_q;
    logic          pend_q;
    pos_t          seg_q;
    logic          vld_q;
    logic          first_q;
    logic          last_q;

    pos_t          head_d;
    logic          wall_d;
    dir_t          dir_d;
    logic          grow_d;
    logic          start_d;
    pos_t          rd_data;
    logic          rd_is_tail;

    // Next head cell, wall test, filtered direction and tick acceptance.
    always_comb begin
        head_d = head_q;
        case (dir_q)
            DIR_RIGHT: head_d.x = head_q.x + 5'd1;
            DIR_DOWN:  head_d.y = head_q.y + 4'd1;
            DIR_LEFT:  head_d.x = head_q.x - 5'd1;
            default:   head_d.y = head_q.y - 4'd1;
        endcase
        wall_d  = is_wall(head_d);
        dir_d   = (dir_t'(bus.i_dir) == opposite(dir_q)) ? dir_q : dir_t'(bus.i_dir);
        grow_d  = grow_q && (len_q < LW'(MAX_LEN));
        start_d = (bus.i_tick || pend_q) && !go_q;
    end

    snake_ring #(.MAX_LEN(MAX_LEN)) u_ring (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         ((state_q == ST_MOVE) && !wall_d),
        .grow_i       (grow_d),
        .wdata_i      (head_d),
        .rd_start_i   (state_q == ST_MOVE),
        .rd_next_i    ((state_q == ST_SCAN) && !last_q),
        .rdata_o      (rd_data),
        .rd_is_tail_o (rd_is_tail)
    );

    // Game FSM: IDLE -> MOVE (one cycle) -> SCAN (one beat per segment) -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            head_q  <= '{x: START_X, y: START_Y};
            len_q   <= LW'(START_LEN);
            grow_q  <= 1'b0;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            seg_q   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A held tick is consumed here whether or not the game is over.
                    pend_q <= 1'b0;
                    if (start_d) begin
                        dir_q   <= dir_d;
                        state_q <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    pend_q  <= bus.i_tick;
                    grow_q  <= 1'b0;
                    state_q <= ST_SCAN;
                    vld_q   <= 1'b1;
                    first_q <= 1'b1;
                    last_q  <= 1'b0;
                    if (wall_d) begin
                        go_q  <= 1'b1;
                        seg_q <= head_q;
                    end else begin
                        head_q <= head_d;
                        seg_q  <= head_d;
                        if (grow_d)
                            len_q <= len_q + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (bus.i_tick)
                        pend_q <= 1'b1;
                    if (bus.i_eat)
                        grow_q <= 1'b1;
                    // The vacated tail is never streamed, so chasing it is legal.
                    if (!first_q && (seg_q == head_q))
                        go_q <= 1'b1;
                    if (last_q) begin
                        state_q <= ST_IDLE;
                        vld_q   <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        seg_q   <= '0;
                    end else begin
                        seg_q   <= rd_data;
                        first_q <= 1'b0;
                        last_q  <= rd_is_tail;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_snake_x     = seg_q.x;
    assign bus.o_snake_y     = seg_q.y;
    assign bus.o_snake_first = first_q;
    assign bus.o_snake_last  = last_q;
    assign bus.o_snake_valid = vld_q;
    assign bus.o_length      = len_q;
    assign bus.o_game_over   = go_q;

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body against a queue-based game model.
module tb_snake_body;

    localparam int ML = 8;
    localparam int LW = $clog2(ML) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_body_if #(.MAX_LEN(ML)) bus();
    snake_body #(.MAX_LEN(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed { logic [4:0] x; logic [3:0] y; } seg_t;
    typedef logic [11:0] word_t;    // {x, y, first, last, game_over}

    seg_t  body[$];                 // head at index 0
    int    mdl_dir;
    bit    mdl_grow, mdl_go;
    word_t exp_w[$], got_w[$];
    int    got_lat;
    int    total = 0, bad = 0;

    task automatic mdl_reset();
        body = {};
        body.push_back('{x: 5'd10, y: 4'd6});
        body.push_back('{x: 5'd9,  y: 4'd6});
        body.push_back('{x: 5'd8,  y: 4'd6});
        mdl_dir = 0; mdl_grow = 0; mdl_go = 0;
    endtask

    // One game step from the rules, producing the expected beat words.
    task automatic mdl_tick(input int d, input int eat_beat);
        int nx, ny, n;
        bit g;
        exp_w = {};
        if (mdl_go) return;
        if (d != (mdl_dir ^ 2)) mdl_dir = d;
        nx = int'(body[0].x) + int'(mdl_dir == 0) - int'(mdl_dir == 2);
        ny = int'(body[0].y) + int'(mdl_dir == 1) - int'(mdl_dir == 3);
        g = (nx < 1 || nx > 20 || ny < 1 || ny > 11);
        if (!g) begin
            body.push_front('{x: 5'(nx), y: 4'(ny)});
            if (!(mdl_grow && (body.size() - 1) < ML)) void'(body.pop_back());
        end
        mdl_grow = 0;
        n = body.size();
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({body[i], i == 0, i == n - 1, g});
            if (i > 0 && body[i] == body[0]) g = 1;
        end
        mdl_go = g;
        if (eat_beat >= 0 && eat_beat < n) mdl_grow = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.i_tick = 1'b0; bus.i_dir = 2'd0; bus.i_eat = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
    endtask

    // Optionally tick, then capture one stream; can pulse eat on a beat and
    // inject two ticks (beats xb, xb+1) with direction xd during the scan.
    task automatic run_stream(input bit tk, input int d, input int eat_beat,
                              input int xb, input int xd);
        bus.i_dir = 2'(d); bus.i_tick = tk;
        got_w = {}; got_lat = -1;
        for (int c = 1; c <= ML + 8; c++) begin
            @(negedge clk);
            bus.i_tick = 1'b0; bus.i_eat = 1'b0;
            if (bus.o_snake_valid) begin
                if (got_lat < 0) got_lat = c;
                if (got_w.size() == eat_beat) bus.i_eat = 1'b1;
                if (xb >= 0 && (got_w.size() == xb || got_w.size() == xb + 1)) begin
                    bus.i_tick = 1'b1; bus.i_dir = 2'(xd);
                end
                got_w.push_back({bus.o_snake_x, bus.o_snake_y, bus.o_snake_first,
                                 bus.o_snake_last, bus.o_game_over});
            end else if (got_lat >= 0) break;
        end
        bus.i_tick = 1'b0; bus.i_eat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (bus.o_snake_valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b exp=0", bus.o_snake_valid); end
        if (bus.o_snake_first !== 1'b0) begin bad++; $display("FAIL reset first got=%b exp=0", bus.o_snake_first); end
        if (bus.o_snake_last !== 1'b0) begin bad++; $display("FAIL reset last got=%b exp=0", bus.o_snake_last); end
        if (bus.o_snake_x !== 5'd0) begin bad++; $display("FAIL reset x got=%0d exp=0", bus.o_snake_x); end
        if (bus.o_snake_y !== 4'd0) begin bad++; $display("FAIL reset y got=%0d exp=0", bus.o_snake_y); end
        if (bus.o_length !== LW'(3)) begin bad++; $display("FAIL reset length got=%0d exp=3", bus.o_length); end
        if (bus.o_game_over !== 1'b0) begin bad++; $display("FAIL reset game_over got=%b exp=0", bus.o_game_over); end
    endtask

    // Table-driven directed sequences: basic move, eat+turn, self hit, tail chase.
    task automatic test_sequences();
        int dirs [4][10] = '{'{0, 1, 9, 9, 9, 9, 9, 9, 9, 9},
                             '{2, 9, 9, 9, 9, 9, 9, 9, 9, 9},
                             '{0, 0, 0, 1, 2, 3, 9, 9, 9, 9},
                             '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1}};
        int eats [4][10] = '{'{0, -1, -1, -1, -1, -1, -1, -1, -1, -1},
                             '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1},
                             '{0, 0, -1, -1, -1, -1, -1, -1, -1, -1},
                             '{0, -1, -1, -1, -1, -1, -1, -1, -1, -1}};
        bit exp_go [4] = '{0, 0, 1, 0};
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int k = 0; k < 10 && dirs[s][k] != 9; k++) begin
                run_stream(1'b1, dirs[s][k], eats[s][k], -1, 0);
                mdl_tick(dirs[s][k], eats[s][k]);
                total++;
                if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL seq%0d step%0d beats got=%0d exp=%0d", s, k, got_w.size(), exp_w.size()); end
                foreach (exp_w[i]) begin
                    total++;
                    if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL seq%0d step%0d beat%0d got=%h exp=%h", s, k, i, (i < got_w.size()) ? got_w[i] : 12'h0, exp_w[i]); end
                end
                total += 3;
                if (got_lat !== 2) begin bad++; $display("FAIL seq%0d step%0d latency got=%0d exp=2", s, k, got_lat); end
                if (bus.o_length !== LW'(body.size())) begin bad++; $display("FAIL seq%0d step%0d length got=%0d exp=%0d", s, k, bus.o_length, body.size()); end
                if (bus.o_game_over !== mdl_go) begin bad++; $display("FAIL seq%0d step%0d game_over got=%b exp=%b", s, k, bus.o_game_over, mdl_go); end
                if (s == 1) begin
                    total++;
                    if (got_w[0][11:3] !== {5'd11, 4'd6}) begin bad++; $display("FAIL reversal head got=%h exp=%h", got_w[0][11:3], {5'd11, 4'd6}); end
                end
            end
            total++;
            if (bus.o_game_over !== exp_go[s]) begin bad++; $display("FAIL seq%0d final game_over got=%b exp=%b", s, bus.o_game_over, exp_go[s]); end
        end
    endtask

    task automatic test_wall();
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            run_stream(1'b1, 3, -1, -1, 0);
            mdl_tick(3, -1);
            total++;
            if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL wall tick%0d beats got=%0d exp=%0d", k, got_w.size(), exp_w.size()); end
            foreach (exp_w[i]) begin
                total++;
                if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL wall tick%0d beat%0d got=%h exp=%h", k, i, (i < got_w.size()) ? got_w[i] : 12'h0, exp_w[i]); end
            end
            total++;
            if (bus.o_game_over !== (k >= 6)) begin bad++; $display("FAIL wall tick%0d game_over got=%b exp=%b", k, bus.o_game_over, k >= 6); end
            if (k == 6) begin
                total++;
                if (got_w.size() == 0 || got_w[0][11:3] !== {5'd10, 4'd1}) begin bad++; $display("FAIL wall head got=%h exp=%h", (got_w.size() > 0) ? got_w[0][11:3] : 9'h0, {5'd10, 4'd1}); end
            end
            if (k == 7) begin
                total++;
                if (got_w.size() !== 0) begin bad++; $display("FAIL wall post-over beats got=%0d exp=0", got_w.size()); end
            end
        end
    endtask

    task automatic test_maxlen();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_stream(1'b1, 0, (k < 7) ? 0 : -1, -1, 0);
            mdl_tick(0, (k < 7) ? 0 : -1);
            total += 2;
            if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL maxlen step%0d beats got=%0d exp=%0d", k, got_w.size(), exp_w.size()); end
            if (bus.o_length !== LW'(body.size())) begin bad++; $display("FAIL maxlen step%0d length got=%0d exp=%0d", k, bus.o_length, body.size()); end
        end
        total++;
        if (bus.o_length !== LW'(ML)) begin bad++; $display("FAIL maxlen cap got=%0d exp=%0d", bus.o_length, ML); end
    endtask

    // Two ticks during a scan are held as one; direction taken at service time.
    task automatic test_pending();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin run_stream(1'b1, 0, -1, 0, 3); mdl_tick(0, -1); end
            else if (k == 1) begin run_stream(1'b0, 1, -1, -1, 0); mdl_tick(1, -1); end
            else begin run_stream(1'b0, 1, -1, -1, 0); exp_w = {}; end
            total++;
            if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL pending run%0d beats got=%0d exp=%0d", k, got_w.size(), exp_w.size()); end
            foreach (exp_w[i]) begin
                total++;
                if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL pending run%0d beat%0d got=%h exp=%h", k, i, (i < got_w.size()) ? got_w[i] : 12'h0, exp_w[i]); end
            end
            if (exp_w.size() > 0) begin
                total++;
                if (got_lat !== 2) begin bad++; $display("FAIL pending run%0d latency got=%0d exp=2", k, got_lat); end
            end
        end
    endtask

    task automatic test_reset_midscan();
        do_reset();
        bus.i_tick = 1'b1; bus.i_dir = 2'd1;
        @(negedge clk); bus.i_tick = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus.o_snake_valid !== 1'b0) begin bad++; $display("FAIL midreset valid got=%b exp=0", bus.o_snake_valid); end
        if (bus.o_length !== LW'(3)) begin bad++; $display("FAIL midreset length got=%0d exp=3", bus.o_length); end
        rst_n = 1'b1;
        mdl_reset();
        run_stream(1'b1, 0, -1, -1, 0);
        mdl_tick(0, -1);
        total++;
        if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL midreset beats got=%0d exp=%0d", got_w.size(), exp_w.size()); end
        foreach (exp_w[i]) begin
            total++;
            if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL midreset beat%0d got=%h exp=%h", i, (i < got_w.size()) ? got_w[i] : 12'h0, exp_w[i]); end
        end
    endtask

    task automatic test_random();
        int d, eb;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            d  = int'($urandom_range(0, 3));
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, body.size())) : -1;
            run_stream(1'b1, d, eb, -1, 0);
            mdl_tick(d, eb);
            total++;
            if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL random it%0d beats got=%0d exp=%0d", it, got_w.size(), exp_w.size()); end
            foreach (exp_w[i]) begin
                total++;
                if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL random it%0d beat%0d got=%h exp=%h", it, i, (i < got_w.size()) ? got_w[i] : 12'h0, exp_w[i]); end
            end
            total += 2;
            if (bus.o_length !== LW'(body.size())) begin bad++; $display("FAIL random it%0d length got=%0d exp=%0d", it, bus.o_length, body.size()); end
            if (bus.o_game_over !== mdl_go) begin bad++; $display("FAIL random it%0d game_over got=%b exp=%b", it, bus.o_game_over, mdl_go); end
            if (mdl_go) do_reset();
        end
    endtask

    initial begin
        bus.i_tick = 1'b0; bus.i_dir = 2'd0; bus.i_eat = 1'b0;
        test_reset();
        test_sequences();
        test_wall();
        test_maxlen();
        test_pending();
        test_reset_midscan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
